// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchronizer, mode-selected edge
// qualification, retriggerable pulse stretcher, sticky status and masked irq.
module edge_detect_multi #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_i,
    input  logic                 en_i,
    input  logic [2*WIDTH-1:0]   mode_i,
    input  logic [WIDTH-1:0]     clr_i,
    input  logic [WIDTH-1:0]     irq_mask_i,
    output logic [WIDTH-1:0]     out_o,
    output logic [WIDTH-1:0]     status_o,
    output logic                 irq_o
);

    localparam int CW = $clog2(PULSE_LEN + 1);
    localparam int AW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] LOAD_VAL = CW'(PULSE_LEN);
    localparam logic [AW-1:0] ARM_VAL  = AW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] d_q;
    logic [AW-1:0]    arm_cnt_q;
    logic             armed_s;
    logic [WIDTH-1:0] s_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] edge_q;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] status_d;
    logic [WIDTH-1:0] status_q;
    logic             irq_q;

    assign s_s     = sync_q[SYNC_STAGES-1];
    assign rise_s  = s_s & ~d_q;
    assign fall_s  = ~s_s & d_q;
    assign armed_s = (arm_cnt_q == ARM_VAL);

    // Synchronizer chain and one-cycle delayed copy; runs regardless of en/mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            d_q <= '0;
        end else begin
            sync_q[0] <= in_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            d_q <= s_s;
        end
    end

    // Arming counter: blocks edges until the sync chain holds real samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt_q <= '0;
        end else if (arm_cnt_q != ARM_VAL) begin
            arm_cnt_q <= arm_cnt_q + AW'(1);
        end else begin
            arm_cnt_q <= arm_cnt_q;
        end
    end

    // Edge qualification by per-channel mode, global enable and armed flag
    always_comb begin
        edge_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode_i[2*i +: 2])
                2'b01:   edge_d[i] = rise_s[i];
                2'b10:   edge_d[i] = fall_s[i];
                2'b11:   edge_d[i] = rise_s[i] | fall_s[i];
                default: edge_d[i] = 1'b0;
            endcase
            edge_d[i] = edge_d[i] & en_i & armed_s;
        end
    end

    // Stretch counters reload on every qualified edge, so retriggers extend without a gap
    always_comb begin
        out_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (edge_q[i]) begin
                cnt_d[i] = LOAD_VAL;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end else begin
                cnt_d[i] = '0;
            end
            out_d[i] = (cnt_d[i] != '0);
        end
        status_d = (status_q & ~clr_i) | edge_q;
    end

    // Edge register, stretch counters, sticky status and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q   <= '0;
            out_q    <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            edge_q   <= edge_d;
            out_q    <= out_d;
            status_q <= status_d;
            irq_q    <= |(status_q & irq_mask_i);
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out_o    = out_q;
    assign status_o = status_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Randomized and directed bench for edge_detect_multi; expected outputs come
// from an index-based sample-history model and are checked by a scoreboard monitor.
module tb_edge_detect_multi;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int P  = 3;

    logic           clk    = 1'b0;
    logic           rst_n  = 1'b0;
    logic [W-1:0]   in_r   = 4'h0;
    logic           en_r   = 1'b1;
    logic [2*W-1:0] mode_r = 8'h55;
    logic [W-1:0]   clr_r  = 4'h0;
    logic [W-1:0]   mask_r = 4'h0;
    logic [W-1:0]   out_s;
    logic [W-1:0]   status_s;
    logic           irq_s;

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] status;
        logic         irq;
    } exp_t;

    exp_t           exp_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;

    logic [W-1:0]   hist_in[$];
    logic           hist_en[$];
    logic [2*W-1:0] hist_mode[$];
    int             last_load[W];
    logic [W-1:0]   m_status;
    int             n_edge;

    edge_detect_multi #(.WIDTH(W), .SYNC_STAGES(SS), .PULSE_LEN(P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_i       (in_r),
        .en_i       (en_r),
        .mode_i     (mode_r),
        .clr_i      (clr_r),
        .irq_mask_i (mask_r),
        .out_o      (out_s),
        .status_o   (status_s),
        .irq_o      (irq_s)
    );

    always #5 clk = ~clk;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        hist_in   = {};
        hist_en   = {};
        hist_mode = {};
        hist_in.push_back(4'h0);
        hist_en.push_back(1'b0);
        hist_mode.push_back(8'h00);
        n_edge   = 0;
        m_status = 4'h0;
        for (int i = 0; i < W; i++) last_load[i] = -1000;
    endtask

    // Edge n of the run loads a pulse for an input change sampled at edge n-SS-1,
    // using en/mode seen at edge n-1, if edge n-1 is at least SS+2 edges after reset.
    task automatic model_edge();
        exp_t           e;
        logic [W-1:0]   set_v;
        logic [W-1:0]   prev_v;
        logic [W-1:0]   cur_v;
        logic [2*W-1:0] md_v;
        logic [1:0]     md;
        int             q;
        int             k;
        n_edge++;
        hist_in.push_back(in_r);
        hist_en.push_back(en_r);
        hist_mode.push_back(mode_r);
        set_v = 4'h0;
        q = n_edge - 1;
        k = n_edge - SS - 1;
        if (q >= SS + 2) begin
            prev_v = hist_in[k-1];
            cur_v  = hist_in[k];
            md_v   = hist_mode[q];
            for (int i = 0; i < W; i++) begin
                md = md_v[2*i +: 2];
                if (hist_en[q] && ((cur_v[i] && !prev_v[i] && md[0]) ||
                                   (!cur_v[i] && prev_v[i] && md[1]))) begin
                    set_v[i]     = 1'b1;
                    last_load[i] = n_edge;
                end
            end
        end
        e.irq    = |(m_status & mask_r);
        m_status = (m_status & ~clr_r) | set_v;
        e.status = m_status;
        for (int i = 0; i < W; i++) e.out[i] = ((n_edge - last_load[i]) < P);
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at a negedge after n rising edges.
    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            if (rst_n) model_edge();
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check("reset_async", {out_s, status_s, irq_s}, 32'h0);
        @(negedge clk);
        step(2);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Scoreboard monitor: compares one expected entry per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out", 32'(out_s), 32'(e.out));
                check("status", 32'(status_s), 32'(e.status));
                check("irq", 32'(irq_s), 32'(e.irq));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        check("reset_state", {out_s, status_s, irq_s}, 32'h0);
        step(2);
        rst_n = 1'b1;
        model_reset();
        step(3);

        // V1: basic rise, then fall gives no pulse in rising mode
        in_r[0] = 1'b1; step(8);
        in_r[0] = 1'b0; step(8);

        // V2: mode sweep on channel 1
        mode_r[3:2] = 2'b10;
        in_r[1] = 1'b1; step(8);
        in_r[1] = 1'b0; step(8);
        mode_r[3:2] = 2'b11;
        in_r[1] = 1'b1; step(8);
        in_r[1] = 1'b0; step(8);
        mode_r[3:2] = 2'b00;
        in_r[1] = 1'b1; step(8);
        in_r[1] = 1'b0; step(8);
        mode_r[3:2] = 2'b01;

        // V3: retrigger on channel 2
        in_r[2] = 1'b1; step(1);
        in_r[2] = 1'b0; step(1);
        in_r[2] = 1'b1; step(10);
        in_r[2] = 1'b0; step(6);

        // V4: reset with all inputs high, then a clean 1->0->1 on channel 3
        in_r = 4'hF;
        do_reset();
        step(12);
        in_r[3] = 1'b0; step(3);
        in_r[3] = 1'b1; step(8);
        in_r = 4'h0; step(8);

        // V5: status and irq on channel 0
        mask_r = 4'b0001;
        in_r[0] = 1'b1; step(8);
        clr_r[0] = 1'b1; step(1);
        clr_r[0] = 1'b0; step(3);
        in_r[0] = 1'b0; step(3);
        in_r[0] = 1'b1; step(3);
        clr_r[0] = 1'b1; step(1);
        clr_r[0] = 1'b0; step(4);
        mask_r = 4'h0; step(2);

        // V6: level change while disabled, fall in both-edge mode, reset mid-pulse
        en_r = 1'b0;
        in_r[1] = 1'b1; step(8);
        en_r = 1'b1; step(8);
        mode_r[3:2] = 2'b11;
        in_r[1] = 1'b0; step(8);
        in_r[1] = 1'b1; step(4);
        do_reset();
        mode_r = 8'h55;
        step(6);

        // Randomized phase
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            if ($urandom_range(3, 0) == 0) in_r[$urandom_range(W-1, 0)] ^= 1'b1;
            en_r  = ($urandom_range(7, 0) != 0);
            clr_r = ($urandom_range(7, 0) == 0) ? 4'($urandom()) : 4'h0;
            if ($urandom_range(15, 0) == 0) mode_r = 8'($urandom());
            if ($urandom_range(15, 0) == 0) mask_r = 4'($urandom());
            step(1);
        end
        clr_r = 4'h0;
        step(8);
        #2;
        check("drain", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
